// File: rtl/dm_responder_if.sv
// dm_responder_if: CPU M-stage data port plus write-trace stream and status counters.
// Signals:
//   m_data_addr/wdata/byteen, m_inst_addr : CPU -> memory request
//   m_data_rdata                          : memory -> CPU read data (combinational)
//   trace_valid/ready/pc/addr/data        : write-trace stream (valid/ready)
//   fault_cnt, drop_cnt                   : saturating status counters
// master = CPU/consumer side, slave = dm_responder.
`timescale 1ns/1ps
interface dm_responder_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [7:0]  fault_cnt;
    logic [7:0]  drop_cnt;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
               fault_cnt, drop_cnt
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
               fault_cnt, drop_cnt
    );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: byte-lane writable data memory for the CPU M stage with an
// optional write-trace FIFO and saturating fault/drop counters.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset of control state (memory untouched)
//   bus   : dm_responder_if.slave (data port, trace stream, counters)
// Parameters:
//   MEM_WORDS   : memory depth in 32-bit words (in-range bytes 0 .. MEM_WORDS*4-1)
//   TRACE_DEPTH : trace FIFO entries, power of two
// Build option: define DM_TRACE_EN to implement the trace FIFO and drop_cnt;
// otherwise the trace outputs and drop_cnt are tied to zero.
`timescale 1ns/1ps
module dm_responder #(
    parameter int unsigned MEM_WORDS   = 3072,
    parameter int unsigned TRACE_DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    dm_responder_if.slave bus
);
    localparam int unsigned IDX_W     = 12;
    localparam int unsigned PTR_W     = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    // Zero at time 0; reset never touches the array.
    logic [31:0] mem [MEM_WORDS] = '{default: '0};

    logic [IDX_W-1:0] idx_c;
    logic             in_range_c;
    logic             any_be_c;
    logic             wr_en_c;
    logic             fault_c;
    logic [31:0]      old_word_c;
    logic [31:0]      merged_c;
    logic [7:0]       fault_cnt_q;

    assign idx_c      = bus.m_data_addr[13:2];
    assign in_range_c = {1'b0, bus.m_data_addr} < MEM_BYTES;
    assign any_be_c   = bus.m_data_byteen != 4'b0000;
    assign wr_en_c    = in_range_c && any_be_c;
    assign fault_c    = !in_range_c && any_be_c;
    assign old_word_c = in_range_c ? mem[idx_c] : 32'h0;

    // Combinational read returns the pre-edge word (read-before-write).
    assign bus.m_data_rdata = old_word_c;

    // Byte-lane merge of write data into the current word.
    always_comb begin
        merged_c = old_word_c;
        for (int i = 0; i < 4; i++) begin
            if (bus.m_data_byteen[i]) begin
                merged_c[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
            end
        end
    end

    // Memory write happens even while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[idx_c] <= merged_c;
        end
    end

    // Saturating count of out-of-range write attempts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_cnt_q <= 8'h00;
        end else if (fault_c && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'h01;
        end
    end

    assign bus.fault_cnt = fault_cnt_q;

`ifdef DM_TRACE_EN
    logic [95:0]      fifo [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       drop_cnt_q;
    logic             valid_c;
    logic             full_c;
    logic             pop_c;
    logic             accept_c;
    logic             drop_c;
    logic [95:0]      head_c;

    assign valid_c  = count_q != '0;
    assign full_c   = count_q == CNT_W'(TRACE_DEPTH);
    assign pop_c    = valid_c && bus.trace_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign accept_c = wr_en_c && (!full_c || pop_c);
    assign drop_c   = wr_en_c && full_c && !pop_c;
    assign head_c   = fifo[rd_ptr_q];

    // Entry storage; stale writes under reset are invisible since pointers clear.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            fifo[wr_ptr_q] <= {bus.m_inst_addr, bus.m_data_addr[31:2], 2'b00, merged_c};
        end
    end

    // Pointers, occupancy and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= 8'h00;
        end else begin
            if (accept_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({accept_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop_c && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'h01;
            end
        end
    end

    assign bus.trace_valid = valid_c;
    assign bus.trace_pc    = valid_c ? head_c[95:64] : 32'h0;
    assign bus.trace_addr  = valid_c ? head_c[63:32] : 32'h0;
    assign bus.trace_data  = valid_c ? head_c[31:0]  : 32'h0;
    assign bus.drop_cnt    = drop_cnt_q;
`else
    logic unused_trace_c;

    assign unused_trace_c  = ^{bus.trace_ready, bus.m_inst_addr};
    assign bus.trace_valid = 1'b0;
    assign bus.trace_pc    = 32'h0;
    assign bus.trace_addr  = 32'h0;
    assign bus.trace_data  = 32'h0;
    assign bus.drop_cnt    = 8'h00;
`endif
endmodule

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
module tb_dm_responder;
`ifdef DM_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dm_responder_if bus ();

    dm_responder #(.MEM_WORDS(3072), .TRACE_DEPTH(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] pc;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
        logic [7:0]  exp_fault;
        bit          exp_push;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tr(input logic [31:0] v);
        return TRACE ? v : 32'h0;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] pc);
        bus.m_data_addr   = a;
        bus.m_data_wdata  = d;
        bus.m_data_byteen = be;
        bus.m_inst_addr   = pc;
    endtask

    // One write edge: inputs set after negedge, byteen dropped 1 ns after posedge.
    task automatic write_edge(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic [31:0] pc);
        @(negedge clk);
        drive(a, d, be, pc);
        @(posedge clk);
        #1;
        bus.m_data_byteen = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(32'h0, 32'h0, 4'b0000, 32'h0);
        bus.trace_ready = 1'b1;

        //           addr          wdata         be       pc            old           new           flt    push
        vecs[0] = '{32'h0000_0000, 32'h1234_5678, 4'b1111, 32'h0000_1000, 32'h0000_0000, 32'h1234_5678, 8'd0, 1'b1};
        vecs[1] = '{32'h0000_0002, 32'hABCD_0000, 4'b1100, 32'h0000_1004, 32'h1234_5678, 32'hABCD_5678, 8'd0, 1'b1};
        vecs[2] = '{32'h0000_3000, 32'h0000_00FF, 4'b0001, 32'h0000_1008, 32'h0000_0000, 32'h0000_0000, 8'd1, 1'b0};
        vecs[3] = '{32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 32'h0000_100C, 32'h0000_0000, 32'h00BB_00DD, 8'd1, 1'b1};
        vecs[4] = '{32'h0000_2FFC, 32'hDEAD_BEEF, 4'b1111, 32'h0000_1010, 32'h0000_0000, 32'hDEAD_BEEF, 8'd1, 1'b1};
        vecs[5] = '{32'h0000_2FFF, 32'h5555_5555, 4'b0000, 32'h0000_1014, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'd1, 1'b0};
        vecs[6] = '{32'hFFFF_0000, 32'h9999_9999, 4'b1111, 32'h0000_1018, 32'h0000_0000, 32'h0000_0000, 8'd2, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h7777_7777, 4'b0000, 32'h0000_101C, 32'hABCD_5678, 32'hABCD_5678, 8'd2, 1'b0};
        vecs[8] = '{32'h0000_0006, 32'h0000_EE00, 4'b0010, 32'h0000_1020, 32'h00BB_00DD, 32'h00BB_EEDD, 8'd2, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_trace_valid", 32'(bus.trace_valid), 32'h0);
        check("rst_fault_cnt",   32'(bus.fault_cnt),   32'h0);
        check("rst_drop_cnt",    32'(bus.drop_cnt),    32'h0);
        check("rst_mem0_zero",   bus.m_data_rdata,     32'h0);
        check("rst_trace_data",  bus.trace_data,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: trace_ready held high, so the head after each edge is that edge's push.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].pc);
            #1;
            check($sformatf("v%0d_rdata_old", i), bus.m_data_rdata, vecs[i].exp_old);
            @(posedge clk);
            #1;
            bus.m_data_byteen = 4'b0000;
            check($sformatf("v%0d_rdata_new", i), bus.m_data_rdata, vecs[i].exp_new);
            check($sformatf("v%0d_fault", i), 32'(bus.fault_cnt), 32'(vecs[i].exp_fault));
            check($sformatf("v%0d_tvalid", i), 32'(bus.trace_valid), 32'(TRACE && vecs[i].exp_push));
            check($sformatf("v%0d_tdata", i), bus.trace_data,
                  vecs[i].exp_push ? tr(vecs[i].exp_new) : 32'h0);
            check($sformatf("v%0d_taddr", i), bus.trace_addr,
                  vecs[i].exp_push ? tr(vecs[i].addr & 32'hFFFF_FFFC) : 32'h0);
            check($sformatf("v%0d_tpc", i), bus.trace_pc,
                  vecs[i].exp_push ? tr(vecs[i].pc) : 32'h0);
        end

        // Idle edge drains the last entry
        @(posedge clk);
        #1;
        check("drain_tvalid", 32'(bus.trace_valid), 32'h0);

        // Overfill: 6 writes with consumer stalled
        bus.trace_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            write_edge(32'h10 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 4'b1111, 32'h2000 + 32'(4 * k));
        end
        check("full_tvalid", 32'(bus.trace_valid), 32'(TRACE));
        check("full_drop",   32'(bus.drop_cnt),    tr(32'd2));
        check("full_head_d", bus.trace_data,       tr(32'hC0DE_0000));
        check("full_head_a", bus.trace_addr,       tr(32'h10));
        check("full_head_p", bus.trace_pc,         tr(32'h2000));

        // Push and pop together while full: no drop, head advances
        @(negedge clk);
        drive(32'h28, 32'hC0DE_0006, 4'b1111, 32'h2018);
        bus.trace_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_data_byteen = 4'b0000;
        bus.trace_ready = 1'b0;
        check("pp_drop",   32'(bus.drop_cnt),    tr(32'd2));
        check("pp_head_d", bus.trace_data,       tr(32'hC0DE_0001));
        check("pp_tvalid", 32'(bus.trace_valid), 32'(TRACE));

        // Pop one more to leave 3 queued
        @(negedge clk);
        bus.trace_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.trace_ready = 1'b0;
        check("pop_head_d", bus.trace_data, tr(32'hC0DE_0002));

        // Short asynchronous reset between edges
        @(negedge clk);
        bus.m_data_addr = 32'h0;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 32'(bus.trace_valid), 32'h0);
        check("arst_fault",  32'(bus.fault_cnt),   32'h0);
        check("arst_drop",   32'(bus.drop_cnt),    32'h0);
        check("arst_tdata",  bus.trace_data,       32'h0);
        check("arst_mem0",   bus.m_data_rdata,     32'hABCD_5678);
        rst_n = 1'b1;
        bus.trace_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_post_tvalid", 32'(bus.trace_valid), 32'h0);

        // Write edges while reset is held: memory written, no push, no fault
        bus.trace_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        drive(32'h30, 32'h5A5A_5A5A, 4'b1111, 32'h3000);
        @(posedge clk);
        #1;
        drive(32'h3004, 32'h1, 4'b0001, 32'h3004);
        @(posedge clk);
        #1;
        bus.m_data_byteen = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        bus.m_data_addr = 32'h30;
        #1;
        check("rstw_mem",    bus.m_data_rdata,     32'h5A5A_5A5A);
        check("rstw_tvalid", 32'(bus.trace_valid), 32'h0);
        check("rstw_fault",  32'(bus.fault_cnt),   32'h0);

        // Fault counter saturation
        @(negedge clk);
        drive(32'h4000, 32'h0, 4'b1111, 32'h0);
        repeat (260) @(posedge clk);
        #1;
        bus.m_data_byteen = 4'b0000;
        check("fault_sat", 32'(bus.fault_cnt), 32'hFF);
        check("mem0_after_faults", bus.m_data_rdata, 32'h0);

        // Drop counter saturation
        @(negedge clk);
        drive(32'h40, 32'hFEED_0000, 4'b1111, 32'h4000);
        repeat (262) @(posedge clk);
        #1;
        bus.m_data_byteen = 4'b0000;
        check("drop_sat",       32'(bus.drop_cnt),    tr(32'hFF));
        check("drop_sat_valid", 32'(bus.trace_valid), 32'(TRACE));
        check("drop_sat_mem",   bus.m_data_rdata,     32'hFEED_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 3072, giving data memory depth in 32-bit words (byte range 0x0000-0x2FFF).
REQ-002 SHALL have parameter TRACE_DEPTH, default 4, giving the write-trace FIFO entry count (power of two).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset of control state.
REQ-006 m_data_addr  input  32  byte address from the CPU M stage.
REQ-007 m_data_wdata  input  32  lane-aligned write data.
REQ-008 m_data_byteen  input  4  byte-lane write enables; 4'b0000 means no write.
REQ-009 m_inst_addr  input  32  PC of the M-stage instruction, captured into trace.
REQ-010 m_data_rdata  output  32  full word at the addressed location, combinational.
REQ-011 trace_valid  output  1  trace FIFO non-empty.
REQ-012 trace_ready  input  1  consumer accepts head entry.
REQ-013 trace_pc  output  32  PC of head entry.
REQ-014 trace_addr  output  32  word-aligned byte address of head entry.
REQ-015 trace_data  output  32  full merged word after the write, head entry.
REQ-016 fault_cnt  output  8  saturating count of out-of-range accesses.
REQ-017 drop_cnt  output  8  saturating count of trace entries lost to full FIFO.

Function
REQ-018 SHALL index memory with m_data_addr[13:2]; addr[1:0] ignored for indexing.
REQ-019 SHALL drive m_data_rdata = mem[index] combinationally when in range; 32'h0 when m_data_addr >= MEM_WORDS*4.
REQ-020 SHALL, on rising clk with byteen != 0 and address in range, write each byte lane i where byteen[i]=1 from wdata[8i+7:8i]; other lanes keep prior value.
REQ-021 SHALL ignore writes to out-of-range addresses; memory unchanged.
REQ-022 SHALL increment fault_cnt by 1 per clock in which address is out of range and byteen != 0, saturating at 8'hFF.
REQ-023 Read of a location written in the same cycle SHALL return the old value until the following edge (read-before-write).
REQ-024 SHALL push one trace entry {m_inst_addr, {addr[31:2],2'b00}, merged word} on every in-range write.
REQ-025 Trace pop SHALL occur on a rising edge with trace_valid=1 and trace_ready=1; head advances one entry.
REQ-026 Push when full and no pop SHALL drop the new entry and increment drop_cnt, saturating at 8'hFF.
REQ-027 Simultaneous push and pop when full SHALL both succeed; occupancy unchanged, no drop.
REQ-028 Simultaneous push and pop when empty SHALL push only; trace_valid=1 next cycle.
REQ-029 Read/write pointers SHALL wrap modulo TRACE_DEPTH; occupancy counter width log2(TRACE_DEPTH)+1.
REQ-030 trace_* data outputs SHALL be 32'h0 whenever trace_valid=0.

Reset
REQ-031 reset low SHALL immediately clear FIFO pointers, occupancy, fault_cnt, drop_cnt; trace_valid=0.
REQ-032 Memory array SHALL be zero at time 0 and SHALL NOT be altered by reset.
REQ-033 A write edge coinciding with reset low SHALL NOT push a trace entry or bump counters; memory write still occurs.
REQ-034 Reset mid-drain SHALL discard all pending trace entries.

Configuration
REQ-035 Macro DM_TRACE_EN: defined -> trace FIFO and drop_cnt implemented per REQ-024..030.
REQ-036 DM_TRACE_EN undefined -> no FIFO storage; trace_valid, trace_pc, trace_addr, trace_data, drop_cnt tied to 0; trace_ready ignored; memory and fault_cnt unchanged.

Verification
REQ-037 Write addr 0x0000 wdata 0x12345678 byteen 4'b1111 -> next cycle rdata 0x12345678; trace head {pc, 0x0, 0x12345678}.
REQ-038 Then addr 0x0002 wdata 0xABCD0000 byteen 4'b1100 -> rdata 0xABCD5678; trace_data 0xABCD5678, trace_addr 0x0.
REQ-039 Addr 0x3000 byteen 4'b0001 -> rdata 0x0, memory unchanged, fault_cnt 1, no trace push.
REQ-040 trace_ready=0, 6 consecutive in-range writes (TRACE_DEPTH 4) -> trace holds first 4, drop_cnt 2; then push+pop same cycle when full -> drop_cnt stays 2.
REQ-041 Reset low for 1 ns between edges with 3 entries queued -> trace_valid 0 immediately, counters 0, mem[0] retains 0xABCD5678.
REQ-042 Build without DM_TRACE_EN, write as REQ-037 -> rdata 0x12345678, trace_valid 0, drop_cnt 0.
